// File: rtl/lenet_pkg.sv
// Shared fixed-point constants and FSM state type for the LeNet convolution datapath.
package lenet_pkg;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 15;
   localparam int Q15_MAX = (1 << FRAC_W) - 1;
   localparam int Q15_MIN = -(1 << FRAC_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_SAT  = 2'd2,
      ST_OUT  = 2'd3
   } conv_state_e;

endpackage

// File: rtl/sat_q15.sv
// Combinational clamp of a wide signed accumulator into the Q1.15 range.
import lenet_pkg::*;

module sat_q15 #(
   parameter int ACC_W = 24
) (
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [DATA_W-1:0] sat_o
);

   localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(Q15_MAX);
   localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(Q15_MIN);

   // Clamp to [Q15_MIN, Q15_MAX]; in-range values pass through as their low bits.
   always_comb begin
      sat_o = acc_i[DATA_W-1:0];
      if (acc_i > MAX_EXT) begin
         sat_o = DATA_W'(Q15_MAX);
      end else if (acc_i < MIN_EXT) begin
         sat_o = DATA_W'(Q15_MIN);
      end
   end

endmodule

// File: rtl/conv_accum.sv
// Convolution window accumulator: sums KERNEL_LEN Q1.15 products plus a bias,
// saturates to Q1.15 and hands the result downstream with valid/ready.
// Optional macro CONV_ACCUM_RELU_EN clips negative saturated results to zero.
// ACC_W must be at least 16 + ceil(log2(KERNEL_LEN+1)) so the sum never wraps.
import lenet_pkg::*;

module conv_accum #(
   parameter int KERNEL_LEN = 25,
   parameter int ACC_W      = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     prod_valid,
   output logic                     prod_ready,
   input  logic signed [DATA_W-1:0] prod_data,
   input  logic signed [DATA_W-1:0] bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     busy
);

   localparam int                CNT_W    = $clog2(KERNEL_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_LEN - 1);

   conv_state_e                state_q, state_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0]   out_data_q, out_data_d;
   logic signed [DATA_W-1:0]   sat_val;
   logic signed [DATA_W-1:0]   res_val;
   logic                       xfer;

   sat_q15 #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc_i (acc_q),
      .sat_o (sat_val)
   );

`ifdef CONV_ACCUM_RELU_EN
   // ReLU on the saturated value: negative results become zero.
   always_comb begin
      res_val = sat_val;
      if (sat_val[DATA_W-1]) begin
         res_val = '0;
      end
   end
`else
   assign res_val = sat_val;
`endif

   assign prod_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
   assign xfer       = prod_valid && prod_ready;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign busy       = (state_q != ST_IDLE);

   // Next-state and datapath update; bubbles leave acc and cnt untouched.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               // The bias is folded in with the first product of the window.
               acc_d   = ACC_W'(bias) + ACC_W'(prod_data);
               cnt_d   = CNT_W'(1);
               state_d = (KERNEL_LEN == 1) ? ST_SAT : ST_ACC;
            end
         end
         ST_ACC: begin
            if (xfer) begin
               acc_d = acc_q + ACC_W'(prod_data);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_SAT;
               end
            end
         end
         ST_SAT: begin
            out_data_d  = res_val;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, accumulator and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_conv_accum.sv
// Bench for conv_accum: table of constant-product windows, hand sequences for
// back-pressure and mid-window reset, and random windows against a sum model.
module tb_conv_accum;

   localparam int KL = 25;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               prod_valid = 1'b0;
   logic               prod_ready;
   logic signed [15:0] prod_data = '0;
   logic signed [15:0] bias = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [15:0] out_data;
   logic               busy;

   int checks = 0;
   int errors = 0;

   logic signed [15:0] prods [KL];

   typedef struct {
      logic signed [15:0] b;
      logic signed [15:0] val;
      int                 bub;
      int                 hold;
      int                 exp_pre;
   } vec_t;

   vec_t tbl [8];

   conv_accum #(
      .KERNEL_LEN (KL),
      .ACC_W      (24)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data),
      .bias       (bias),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int relu(input int x);
`ifdef CONV_ACCUM_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   // Reference: bias plus every product, clamped to Q1.15, optional ReLU.
   function automatic int model(input int b);
      int s;
      s = b;
      for (int i = 0; i < KL; i++) s += int'(prods[i]);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return relu(s);
   endfunction

   // Feed one window from prods[], then check latency, hold and handshake.
   task automatic run_window(input string tag, input logic signed [15:0] b,
                             input int bubble_pct, input int hold, input int exp);
      logic signed [15:0] held;
      int bn;
      for (int i = 0; i < KL; i++) begin
         @(negedge clk);
         bn = 0;
         while (bubble_pct > 0 && $urandom_range(99) < bubble_pct && bn < 20) begin
            prod_valid = 1'b0;
            bias       = 16'($urandom);
            bn++;
            @(negedge clk);
         end
         prod_valid = 1'b1;
         prod_data  = prods[i];
         bias       = (i == 0) ? b : 16'($urandom);
         if (prod_ready !== 1'b1) check({tag, " prod_ready_accept"}, int'(prod_ready), 1);
         @(posedge clk);
      end
      #1;
      prod_valid = 1'b0;
      check({tag, " valid_one_cycle_after_last"}, int'(out_valid), 0);
      check({tag, " busy_in_sat"}, int'(busy), 1);
      @(posedge clk);
      #1;
      check({tag, " valid_two_cycles_after_last"}, int'(out_valid), 1);
      check({tag, " out_data"}, int'(out_data), exp);
      held = out_data;
      // Upstream presents a product while the result is pending; it must wait.
      prod_valid = 1'b1;
      prod_data  = 16'sh7FFF;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({tag, " hold_valid"}, int'(out_valid), 1);
         check({tag, " hold_data"}, int'(out_data), int'(held));
         check({tag, " hold_prod_ready"}, int'(prod_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready  = 1'b0;
      prod_valid = 1'b0;
      check({tag, " valid_drop_after_hs"}, int'(out_valid), 0);
      check({tag, " idle_after_hs"}, int'(busy), 0);
      check({tag, " ready_after_hs"}, int'(prod_ready), 1);
   endtask

   initial begin
      int b;
      int mode;

      tbl[0] = '{16'sh0000, 16'sh0100, 0, 0, 6400};
      tbl[1] = '{16'sh0000, 16'sh7FFF, 0, 1, 32767};
      tbl[2] = '{16'sh0000, 16'sh8000, 0, 10, -32768};
      tbl[3] = '{16'shFC18, 16'sh0000, 0, 2, -1000};
      tbl[4] = '{16'sh0000, 16'sh0010, 30, 0, 400};
      tbl[5] = '{16'sh0064, -16'sd4, 0, 0, 0};
      tbl[6] = '{-16'sd5, 16'sh0001, 20, 3, 20};
      tbl[7] = '{16'sh7FFF, -16'sd1, 0, 1, 32742};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      check("reset busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset prod_ready", int'(prod_ready), 1);

      // Table-driven constant-product windows
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < KL; i++) prods[i] = tbl[t].val;
         run_window($sformatf("tbl%0d", t), tbl[t].b, tbl[t].bub, tbl[t].hold,
                    relu(tbl[t].exp_pre));
      end

      // Products 1..25 with 50% bubbles
      for (int i = 0; i < KL; i++) prods[i] = 16'(i + 1);
      run_window("ramp_bubbles", 16'sh0000, 50, 1, 325);

      // Reset in the middle of a window discards the partial sum
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         prod_valid = 1'b1;
         prod_data  = 16'sh0123;
         bias       = 16'sh0100;
         @(posedge clk);
      end
      @(negedge clk);
      prod_valid = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("midreset out_valid", int'(out_valid), 0);
      check("midreset out_data", int'(out_data), 0);
      check("midreset busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midreset prod_ready", int'(prod_ready), 1);
      for (int i = 0; i < KL; i++) prods[i] = 16'sh0010;
      run_window("after_reset", 16'sh0000, 0, 0, 400);

      // Random windows against the reference model
      for (int w = 0; w < 8; w++) begin
         mode = w % 3;
         for (int i = 0; i < KL; i++) begin
            if (mode == 0)      prods[i] = 16'($urandom);
            else if (mode == 1) prods[i] = 16'(int'($urandom_range(200)) - 100);
            else                prods[i] = 16'(int'($urandom_range(3000)) - 1000);
         end
         b = (mode == 1) ? int'($urandom_range(2000)) - 1000 : int'(16'($urandom));
         b = int'(16'(b));
         run_window($sformatf("rand%0d", w), 16'(b), 50, int'($urandom_range(3)), model(b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
